// File: rtl/mem_access_unit_if.sv
// Request/response bus between the MEM stage and the memory access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        stall;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit with fixed-latency word storage,
// byte/half/word lanes (little-endian) and alignment/range error responses.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_write;
    logic [1:0]      r_size;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata, w_rdata_nxt;
    logic            r_error, w_error_nxt;
    logic [31:0]     r_mem [MEM_WORDS] = '{default: 32'h0};

    logic            w_accept, w_req_err, w_commit;
    logic [AW-1:0]   w_idx;
    logic [4:0]      w_shamt;
    logic [31:0]     w_word, w_shifted, w_load, w_wlanes;
    logic [3:0]      w_be;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_idx    = r_addr[AW+1:2];
    assign w_shamt  = {r_addr[1:0], 3'b000};
    assign w_word   = r_mem[w_idx];
    assign w_shifted = w_word >> w_shamt;
    assign w_wlanes = r_wdata << w_shamt;

    // Request legality is judged on the live inputs in the acceptance cycle.
    always_comb begin
        w_req_err = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
        case (bus.req_size)
            2'b00:   w_req_err = w_req_err;
            2'b01:   w_req_err = w_req_err | bus.req_addr[0];
            2'b10:   w_req_err = w_req_err | (bus.req_addr[1:0] != 2'b00);
            default: w_req_err = 1'b1;
        endcase
    end

    always_comb begin
        w_load = w_word;
        w_be   = 4'b1111;
        case (r_size)
            2'b00: begin
                w_load = w_shifted & 32'h0000_00FF;
                w_be   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_load = w_shifted & 32'h0000_FFFF;
                w_be   = 4'b0011 << r_addr[1:0];
            end
            default: ;
        endcase
    end

    // Next-state and next-response logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rdata_nxt = '0;
        w_error_nxt = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err) begin
                        w_state_nxt = RESP;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (r_cnt == CW'(LATENCY - 1)) begin
                    w_state_nxt = RESP;
                    w_commit    = r_write;
                    w_rdata_nxt = r_write ? 32'h0 : w_load;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_write <= bus.req_write;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr[AW+1:0];
            r_wdata <= bus.req_wdata;
        end
    end

    // Store commits on the ACCESS->RESP edge unless reset wins that edge.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;
    assign bus.stall      = bus.req_valid & ~bus.resp_valid;
endmodule
